// File: rtl/regfile_write_arbiter_if.sv
// Write-request handshake bundle for regfile_write_arbiter: pipeline write-back (wb_*)
// and loader/debug (ld_*) requesters.
interface regfile_write_arbiter_if;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_ready;

    logic        ld_valid;
    logic [3:0]  ld_dest;
    logic [31:0] ld_data;
    logic        ld_ready;

    modport master (
        output wb_valid, wb_dest, wb_data,
        input  wb_ready,
        output ld_valid, ld_dest, ld_data,
        input  ld_ready
    );

    modport slave (
        input  wb_valid, wb_dest, wb_data,
        output wb_ready,
        input  ld_valid, ld_dest, ld_data,
        output ld_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with 1-entry holding buffers and a registered write port.
// Optional round-robin contention policy: define WB_ARB_ROUND_ROBIN_EN (default: wb fixed priority).
module regfile_write_arbiter (
    input  logic                          clk,
    input  logic                          rst,
    regfile_write_arbiter_if.slave        bus,
    input  logic                          freeze,
    output logic                          writeBackEn,
    output logic [3:0]                    dest,
    output logic [31:0]                   result_wb,
    output logic [15:0]                   busy_mask
);

    typedef struct packed {
        logic        valid;
        logic [3:0]  dest;
        logic [31:0] data;
    } entry_t;

    entry_t wb_buf;
    entry_t ld_buf;
    logic   grant_wb;
    logic   grant_ld;
    logic   wb_prio;
    logic   wb_accept;
    logic   ld_accept;

`ifdef WB_ARB_ROUND_ROBIN_EN
    typedef enum logic {
        PTR_WB,
        PTR_LD
    } ptr_t;

    ptr_t ptr;
    ptr_t ptr_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= PTR_WB;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Pointer names the requester favoured on the next contention; moves only on a grant.
    always_comb begin
        ptr_next = ptr;
        if (grant_wb) begin
            ptr_next = PTR_LD;
        end else if (grant_ld) begin
            ptr_next = PTR_WB;
        end
    end

    assign wb_prio = (ptr == PTR_WB);
`else
    assign wb_prio = 1'b1;
`endif

    // Grant depends only on buffer occupancy, freeze and the priority selector.
    always_comb begin
        grant_wb = 1'b0;
        grant_ld = 1'b0;
        if (!freeze) begin
            if (wb_buf.valid && (!ld_buf.valid || wb_prio)) begin
                grant_wb = 1'b1;
            end else if (ld_buf.valid) begin
                grant_ld = 1'b1;
            end
        end
    end

    assign bus.wb_ready = rst && (!wb_buf.valid || grant_wb);
    assign bus.ld_ready = rst && (!ld_buf.valid || grant_ld);

    assign wb_accept = bus.wb_valid && bus.wb_ready;
    assign ld_accept = bus.ld_valid && bus.ld_ready;

    // A refill at the granting edge overwrites the departing entry, so a lone stream has no bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_buf <= '0;
        end else if (wb_accept) begin
            wb_buf <= '{valid: 1'b1, dest: bus.wb_dest, data: bus.wb_data};
        end else if (grant_wb) begin
            wb_buf.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_buf <= '0;
        end else if (ld_accept) begin
            ld_buf <= '{valid: 1'b1, dest: bus.ld_dest, data: bus.ld_data};
        end else if (grant_ld) begin
            ld_buf.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            writeBackEn <= 1'b0;
            dest        <= '0;
            result_wb   <= '0;
        end else if (grant_wb) begin
            writeBackEn <= 1'b1;
            dest        <= wb_buf.dest;
            result_wb   <= wb_buf.data;
        end else if (grant_ld) begin
            writeBackEn <= 1'b1;
            dest        <= ld_buf.dest;
            result_wb   <= ld_buf.data;
        end else begin
            writeBackEn <= 1'b0;
        end
    end

    // A register stays busy until its write is visible on the output register.
    always_comb begin
        busy_mask = '0;
        if (wb_buf.valid) begin
            busy_mask[wb_buf.dest] = 1'b1;
        end
        if (ld_buf.valid) begin
            busy_mask[ld_buf.dest] = 1'b1;
        end
        if (writeBackEn) begin
            busy_mask[dest] = 1'b1;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) !(grant_wb && grant_ld));
    a_no_grant_frozen: assert property (@(posedge clk) disable iff (!rst) freeze |-> !(grant_wb || grant_ld));

endmodule
